id_ctrl_pipe: RTL and testbench

- Registered successor to the combinational main decoder.
- Decodes op/funct/rt from the ID-stage instruction into the 11-bit control bundle, then registers the bundle into the ID/EX boundary with valid, stall and flush handling.
- Adds a parametrised HILO interlock: after MULT/MULTU/DIV/DIVU issue, a counter models unit latency and stalls fetch/decode on any HILO consumer until the unit is done.
- Flags illegal encodings.

---
 rtl/id_ctrl_pipe.sv | 189 ++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: ID-stage main decoder with a registered ID/EX control bundle
// and a HILO interlock for multi-cycle multiply/divide.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   instr holds a real instruction
//   instr      ID-stage instruction (op=[31:26], rt=[20:16], funct=[5:0])
//   stall_in   EX cannot accept; hold the output register
//   flush      kill the output register contents
//   stall_out  combinational: hold IF/ID, HILO consumer waiting on busy unit
//   out_valid  output register holds a live instruction
//   ctrl       {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,jal,jr,bal,hilo_en}
//   illegal    registered instruction is an undefined encoding
//   hilo_busy  combinational: HILO interlock active
module id_ctrl_pipe #(
    parameter int unsigned MULT_CYCLES = 2,
    parameter int unsigned DIV_CYCLES  = 34,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_out,
    output logic        out_valid,
    output logic [10:0] ctrl,
    output logic        illegal,
    output logic        hilo_busy
);

    // Opcode / funct / rt encodings
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    logic [5:0]       op;
    logic [4:0]       rt;
    logic [5:0]       funct;
    logic [10:0]      dec_ctrl;
    logic             dec_illegal;
    logic             is_muldiv;
    logic             is_div;
    logic             is_hilo_use;
    logic             muldiv_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             issue;
    logic             unused_bits;

    assign op          = instr[31:26];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:21], instr[15:6]};

    // Main decoder
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        is_muldiv   = 1'b0;
        is_div      = 1'b0;
        is_hilo_use = 1'b0;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: dec_ctrl = 11'b10100000000;
            OP_J:                                  dec_ctrl = 11'b00000010000;
            OP_JAL:                                dec_ctrl = 11'b10000001000;
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:      dec_ctrl = 11'b00010000000;
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:   dec_ctrl = 11'b10100100000;
            OP_SB, OP_SH, OP_SW:                   dec_ctrl = 11'b00101000000;
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ:     dec_ctrl = 11'b00010000000;
                    RT_BLTZAL, RT_BGEZAL: dec_ctrl = 11'b10010000010;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_MFHI, FN_MFLO: begin
                        dec_ctrl    = 11'b11000000000;
                        is_hilo_use = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        dec_ctrl    = 11'b00000000001;
                        is_hilo_use = 1'b1;
                    end
                    FN_MULT, FN_MULTU: begin
                        dec_ctrl    = 11'b00000000001;
                        is_muldiv   = 1'b1;
                        is_hilo_use = 1'b1;
                    end
                    FN_DIV, FN_DIVU: begin
                        dec_ctrl    = 11'b00000000001;
                        is_muldiv   = 1'b1;
                        is_div      = 1'b1;
                        is_hilo_use = 1'b1;
                    end
                    FN_JR:   dec_ctrl = 11'b00000000100;
                    FN_JALR: dec_ctrl = 11'b11000000100;
                    // Remaining R-type functs are not validated here
                    default: dec_ctrl = 11'b11000000000;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A muldiv sitting in the register counts as busy before it issues
    assign busy      = (cnt != '0) | (out_valid & muldiv_q);
    assign hilo_busy = busy;
    assign stall_out = in_valid & is_hilo_use & busy;
    assign issue     = out_valid & muldiv_q & ~stall_in & ~flush;

    // ID/EX output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            ctrl      <= '0;
            illegal   <= 1'b0;
            muldiv_q  <= 1'b0;
            is_div_q  <= 1'b0;
        end else if (flush || (!stall_in && stall_out)) begin
            out_valid <= 1'b0;
            ctrl      <= '0;
            illegal   <= 1'b0;
            muldiv_q  <= 1'b0;
            is_div_q  <= 1'b0;
        end else if (!stall_in) begin
            out_valid <= in_valid;
            ctrl      <= in_valid ? dec_ctrl : '0;
            illegal   <= in_valid & dec_illegal;
            muldiv_q  <= in_valid & is_muldiv;
            is_div_q  <= in_valid & is_div;
        end
    end

    // HILO latency counter; flush leaves an issued op running to completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= is_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
module tb_id_ctrl_pipe;

    localparam int unsigned MULT_C = 2;
    localparam int unsigned DIV_C  = 34;

    localparam logic [31:0] I_ORI  = 32'h34010005;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_DIV  = 32'h0043001A;
    localparam logic [31:0] I_MULT = 32'h00430018;
    localparam logic [31:0] I_MFLO = 32'h00001012;
    localparam logic [31:0] I_MFHI = 32'h00000010;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] instr;
    logic        stall_in;
    logic        flush;
    logic        stall_out;
    logic        out_valid;
    logic [10:0] ctrl;
    logic        illegal;
    logic        hilo_busy;

    int checks = 0;
    int errors = 0;

    id_ctrl_pipe #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .instr(instr),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
        .out_valid(out_valid), .ctrl(ctrl), .illegal(illegal), .hilo_busy(hilo_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode: instruction classes straight from the opcode table
    typedef struct packed {
        logic [10:0] ctrl;
        logic        ill;
        logic [1:0]  kind;     // 0 none, 1 mult, 2 div
        logic        hilo_use;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [5:0] op, fn;
        logic [4:0] rt;
        op = i[31:26]; fn = i[5:0]; rt = i[20:16];
        d = '0;
        if (op inside {[6'h08:6'h0F]})                  d.ctrl = 11'b10100000000;
        else if (op == 6'h02)                           d.ctrl = 11'b00000010000;
        else if (op == 6'h03)                           d.ctrl = 11'b10000001000;
        else if (op inside {[6'h04:6'h07]})             d.ctrl = 11'b00010000000;
        else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) d.ctrl = 11'b10100100000;
        else if (op inside {6'h28, 6'h29, 6'h2B})       d.ctrl = 11'b00101000000;
        else if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01})               d.ctrl = 11'b00010000000;
            else if (rt inside {5'h10, 5'h11})          d.ctrl = 11'b10010000010;
            else                                        d.ill  = 1'b1;
        end else if (op == 6'h00) begin
            d.ctrl = 11'b11000000000;
            if (fn inside {6'h10, 6'h12}) d.hilo_use = 1'b1;
            if (fn inside {[6'h11:6'h13]} && fn != 6'h12) begin
                d.ctrl = 11'b00000000001; d.hilo_use = 1'b1;
            end
            if (fn inside {[6'h18:6'h1B]}) begin
                d.ctrl = 11'b00000000001; d.hilo_use = 1'b1;
                d.kind = (fn >= 6'h1A) ? 2'd2 : 2'd1;
            end
            if (fn == 6'h08) d.ctrl = 11'b00000000100;
            if (fn == 6'h09) d.ctrl = 11'b11000000100;
        end else d.ill = 1'b1;
        return d;
    endfunction

    // Model state: register contents plus the edge number at which HILO frees
    logic        m_valid;
    logic [10:0] m_ctrl;
    logic        m_ill;
    logic [1:0]  m_kind;
    int          cyc;
    int          free_at;

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_ill = 0; m_kind = 0; cyc = 0; free_at = 0;
    endtask

    // One random cycle: inputs already driven at negedge
    task automatic rnd_cycle();
        dec_t d;
        bit busy, stall, issue;
        #1;
        d     = ref_decode(instr);
        busy  = (cyc < free_at) || (m_valid && m_kind != 0);
        stall = in_valid && d.hilo_use && busy;
        check("stall_out", {31'b0, stall_out}, {31'b0, stall});
        check("hilo_busy", {31'b0, hilo_busy}, {31'b0, busy});
        check("issue_while_busy", {31'b0, dut.issue && (dut.cnt != 0)}, 32'd0);
        issue = m_valid && m_kind != 0 && !stall_in && !flush;
        if (issue) free_at = cyc + 1 + int'(m_kind == 2 ? DIV_C : MULT_C);
        if (flush || (!stall_in && stall)) begin
            m_valid = 0; m_ctrl = '0; m_ill = 0; m_kind = 0;
        end else if (!stall_in) begin
            m_valid = in_valid;
            m_ctrl  = in_valid ? d.ctrl : '0;
            m_ill   = in_valid & d.ill;
            m_kind  = in_valid ? d.kind : 2'd0;
        end
        cyc++;
        @(posedge clk); @(negedge clk);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("ctrl", {21'b0, ctrl}, {21'b0, m_ctrl});
        check("illegal", {31'b0, illegal}, {31'b0, m_ill});
    endtask

    task automatic idle(input int n);
        in_valid = 0; stall_in = 0; flush = 0;
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    // Muldiv followed by a held HILO consumer; measures stall length and capture edge
    task automatic muldiv_then_use(input logic [31:0] md, input int lat, input string nm);
        int stalls, edges;
        bit done;
        instr = md; in_valid = 1;
        @(posedge clk); @(negedge clk);
        check({nm, "_cap"}, {21'b0, ctrl}, 32'b00000000001);
        instr = I_MFLO;
        stalls = 0; edges = 0; done = 0;
        while (!done && edges < 100) begin
            #1;
            if (stall_out) stalls++;
            @(posedge clk); edges++; @(negedge clk);
            if (out_valid) done = 1;
        end
        check({nm, "_stall_cycles"}, stalls, lat + 1);
        check({nm, "_capture_edge"}, edges, lat + 2);
        check({nm, "_mflo_ctrl"}, {21'b0, ctrl}, 32'b11000000000);
        idle(2);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic [10:0] ctrl;
        logic        ill;
        logic        ov;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'h34010005, 1, 11'b10100000000, 0, 1};  // ORI
        vecs[1]  = '{32'h3C011234, 1, 11'b10100000000, 0, 1};  // LUI
        vecs[2]  = '{32'h08000000, 1, 11'b00000010000, 0, 1};  // J
        vecs[3]  = '{32'h0C000000, 1, 11'b10000001000, 0, 1};  // JAL
        vecs[4]  = '{32'h10000000, 1, 11'b00010000000, 0, 1};  // BEQ
        vecs[5]  = '{32'h8C220004, 1, 11'b10100100000, 0, 1};  // LW
        vecs[6]  = '{32'hAC220004, 1, 11'b00101000000, 0, 1};  // SW
        vecs[7]  = '{32'h04000000, 1, 11'b00010000000, 0, 1};  // BLTZ
        vecs[8]  = '{32'h04110000, 1, 11'b10010000010, 0, 1};  // BGEZAL
        vecs[9]  = '{32'h04050000, 1, 11'b00000000000, 1, 1};  // REGIMM rt=5
        vecs[10] = '{32'hFC000000, 1, 11'b00000000000, 1, 1};  // op 0x3F
        vecs[11] = '{32'h00430820, 1, 11'b11000000000, 0, 1};  // ADD
        vecs[12] = '{32'h03E00008, 1, 11'b00000000100, 0, 1};  // JR
        vecs[13] = '{32'h0040F809, 1, 11'b11000000100, 0, 1};  // JALR
        vecs[14] = '{32'h00400011, 1, 11'b00000000001, 0, 1};  // MTHI
        vecs[15] = '{32'hFC000000, 0, 11'b00000000000, 0, 0};  // invalid slot

        resetn = 0; in_valid = 0; instr = '0; stall_in = 0; flush = 0;
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_ctrl", {21'b0, ctrl}, 0);
        check("rst_illegal", {31'b0, illegal}, 0);
        check("rst_hilo_busy", {31'b0, hilo_busy}, 0);
        @(negedge clk); resetn = 1;

        // Single-cycle decode table
        for (int k = 0; k < 16; k++) begin
            instr = vecs[k].instr; in_valid = vecs[k].vld;
            #1;
            check($sformatf("vec%0d_stall", k), {31'b0, stall_out}, 0);
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d_ov", k), {31'b0, out_valid}, {31'b0, vecs[k].ov});
            check($sformatf("vec%0d_ctrl", k), {21'b0, ctrl}, {21'b0, vecs[k].ctrl});
            check($sformatf("vec%0d_ill", k), {31'b0, illegal}, {31'b0, vecs[k].ill});
        end
        idle(1);

        muldiv_then_use(I_DIV, DIV_C, "div");
        muldiv_then_use(I_MULT, MULT_C, "mult");

        // Flush on the MULT's issue edge: no latency is started
        instr = I_MULT; in_valid = 1;
        @(posedge clk); @(negedge clk);
        instr = I_MFHI; flush = 1;
        @(posedge clk); @(negedge clk);
        flush = 0; #1;
        check("flush_busy", {31'b0, hilo_busy}, 0);
        check("flush_stall", {31'b0, stall_out}, 0);
        @(posedge clk); @(negedge clk);
        check("flush_mfhi_ov", {31'b0, out_valid}, 1);
        check("flush_mfhi_ctrl", {21'b0, ctrl}, 32'b11000000000);
        idle(1);

        // stall_in holds LW for 5 edges
        instr = I_LW; in_valid = 1;
        @(posedge clk); @(negedge clk);
        stall_in = 1; instr = I_ORI;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("hold%0d_ov", k), {31'b0, out_valid}, 1);
            check($sformatf("hold%0d_ctrl", k), {21'b0, ctrl}, 32'b10100100000);
        end
        stall_in = 0;
        @(posedge clk); @(negedge clk);
        check("hold_release_ctrl", {21'b0, ctrl}, 32'b10100000000);
        idle(1);

        // Async reset in the middle of a divide (cnt = 20)
        instr = I_DIV; in_valid = 1;
        @(posedge clk); @(negedge clk);
        instr = I_MFHI;
        repeat (15) begin @(posedge clk); @(negedge clk); end
        #1;
        check("middiv_stall", {31'b0, stall_out}, 1);
        check("middiv_cnt", {26'b0, dut.cnt}, 20);
        #2 resetn = 0;
        #1;
        check("arst_ov", {31'b0, out_valid}, 0);
        check("arst_stall", {31'b0, stall_out}, 0);
        check("arst_busy", {31'b0, hilo_busy}, 0);
        @(negedge clk); resetn = 1; #1;
        check("post_rst_stall", {31'b0, stall_out}, 0);
        @(posedge clk); @(negedge clk);
        check("post_rst_mfhi_ov", {31'b0, out_valid}, 1);
        check("post_rst_mfhi_ctrl", {21'b0, ctrl}, 32'b11000000000);

        // Randomized run against the reference model
        resetn = 0; in_valid = 0; #2 resetn = 1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pool [12];
            pool = '{I_ORI, I_LW, 32'hAC220004, 32'h04110000, 32'h04050000, I_MFHI,
                     I_MFLO, 32'h00400013, I_MULT, 32'h00430019, I_DIV, 32'h0043001B};
            instr    = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 11)];
            in_valid = ($urandom_range(0, 9) < 8);
            stall_in = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 19) == 0);
            rnd_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
